// File: rtl/pacman_pkg.sv
// Shared Pac-Man definitions: map geometry, tile codes and the
// tile-map writer state encoding.
//   No ports; imported by tile_addr_calc and tile_map_writer.
package pacman_pkg;

  localparam int MAP_W     = 48;
  localparam int MAP_H     = 27;
  localparam int TILE_W    = 40;
  localparam int TILE_H    = 40;
  localparam int MAP_TILES = MAP_W * MAP_H;

  localparam logic [3:0] TILE_EMPTY = 4'd0;
  localparam logic [3:0] TILE_WALL  = 4'd1;
  localparam logic [3:0] TILE_COIN  = 4'd2;

  typedef enum logic [2:0] {
    ST_SCAN = 3'd0,
    ST_IDLE = 3'd1,
    ST_RD   = 3'd2,
    ST_WAIT = 3'd3,
    ST_CHK  = 3'd4,
    ST_WR   = 3'd5
  } wr_state_t;

  // Only code 2 is a coin; every other non-wall code behaves as empty.
  function automatic logic is_coin(input logic [3:0] code);
    return (code == TILE_COIN);
  endfunction

endpackage

// File: rtl/tile_addr_calc.sv
// Pixel position -> tile address, purely combinational.
// The sprite centre (top-left + half a tile) picks the tile; the tile
// coordinates are clamped to the map and flattened as ty*MAP_W+tx.
//   px, py    : sprite top-left corner in pixels (12 bits each)
//   tile_addr : flattened tile index, 0..MAP_TILES-1
module tile_addr_calc
  import pacman_pkg::*;
(
  input  logic [11:0] px,
  input  logic [11:0] py,
  output logic [10:0] tile_addr
);

  logic [12:0] cx_s;
  logic [12:0] cy_s;
  logic [12:0] qx_s;
  logic [12:0] qy_s;
  logic [5:0]  tx_s;
  logic [4:0]  ty_s;

  // 13 bits so that 4095+20 does not wrap
  assign cx_s = {1'b0, px} + 13'(TILE_W / 2);
  assign cy_s = {1'b0, py} + 13'(TILE_H / 2);

  // Constant divisor: synthesises to a fixed multiply/shift network
  assign qx_s = cx_s / 13'(TILE_W);
  assign qy_s = cy_s / 13'(TILE_H);

  assign tx_s = (qx_s > 13'(MAP_W - 1)) ? 6'(MAP_W - 1) : qx_s[5:0];
  assign ty_s = (qy_s > 13'(MAP_H - 1)) ? 5'(MAP_H - 1) : qy_s[4:0];

  assign tile_addr = 11'(ty_s) * 11'(MAP_W) + 11'(tx_s);

endmodule

// File: rtl/tile_map_writer.sv
// Write-side owner of the tile-map BRAM port B.
// After reset it scans the whole map and counts coin tiles; then once per
// frame it reads the tile under Pac-Man and, if it is a coin, clears it,
// adds COIN_POINTS to the saturating score and decrements the coin count.
// level_clear is sticky once the count reaches zero.
//   clk_pix, reset          : pixel clock, synchronous active-high reset
//   frame_tick              : one pulse per frame
//   pac_x, pac_y            : Pac-Man sprite top-left, pixels
//   map_enb/web/addrb/dinb  : BRAM port B controls
//   map_doutb               : BRAM port B read data (1-cycle latency)
//   score, coins_left       : game counters
//   busy, level_clear       : status
module tile_map_writer
  import pacman_pkg::*;
#(
  parameter int COIN_POINTS = 10,
  parameter int SCORE_W     = 16
) (
  input  logic               clk_pix,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [11:0]        pac_x,
  input  logic [11:0]        pac_y,
  output logic               map_enb,
  output logic               map_web,
  output logic [10:0]        map_addrb,
  output logic [3:0]         map_dinb,
  input  logic [3:0]         map_doutb,
  output logic [SCORE_W-1:0] score,
  output logic [10:0]        coins_left,
  output logic               busy,
  output logic               level_clear
);

  wr_state_t          state_r;
  wr_state_t          state_s;
  logic               live_r;
  logic [10:0]        scan_addr_r;
  logic               scan_vld_r;
  logic [10:0]        tile_addr_r;
  logic [10:0]        calc_addr_s;
  logic [SCORE_W-1:0] score_r;
  logic [10:0]        coins_r;
  logic               level_clear_r;

  logic               scan_issue_s;
  logic               scan_done_s;
  logic               coin_hit_s;
  logic               enb_s;
  logic               web_s;
  logic               busy_s;
  logic [10:0]        addr_s;
  logic [SCORE_W:0]   score_sum_s;
  logic [SCORE_W-1:0] score_s;
  logic [10:0]        coins_s;
  logic               level_clear_s;

  tile_addr_calc u_addr (
    .px        (pac_x),
    .py        (pac_y),
    .tile_addr (calc_addr_s)
  );

  // live_r keeps every output at 0 while reset is held, even though the
  // state register already sits in SCAN.
  assign scan_issue_s = live_r && (state_r == ST_SCAN) && (scan_addr_r < 11'(MAP_TILES));
  assign scan_done_s  = live_r && (state_r == ST_SCAN) && (scan_addr_r == 11'(MAP_TILES));
  assign coin_hit_s   = scan_vld_r && is_coin(map_doutb);
  assign score_sum_s  = {1'b0, score_r} + (SCORE_W + 1)'(COIN_POINTS);

  // State register
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state_r <= ST_SCAN;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and port-B control decode
  always_comb begin
    state_s = state_r;
    enb_s   = 1'b0;
    web_s   = 1'b0;
    busy_s  = 1'b1;
    addr_s  = tile_addr_r;
    case (state_r)
      ST_SCAN: begin
        enb_s  = scan_issue_s;
        addr_s = scan_addr_r;
        if (scan_done_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SCAN;
        end
      end
      ST_IDLE: begin
        busy_s = 1'b0;
        if (frame_tick) begin
          state_s = ST_RD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        enb_s   = 1'b1;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        state_s = ST_CHK;
      end
      ST_CHK: begin
        if (is_coin(map_doutb)) begin
          state_s = ST_WR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR: begin
        enb_s   = 1'b1;
        web_s   = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ST_SCAN;
      end
    endcase
  end

  // Counter next values: scan counting, eat update, sticky level clear
  always_comb begin
    coins_s       = coins_r;
    score_s       = score_r;
    level_clear_s = level_clear_r;
    if (coin_hit_s) begin
      coins_s = coins_r + 11'd1;
    end else if ((state_r == ST_WR) && (coins_r != 11'd0)) begin
      coins_s = coins_r - 11'd1;
    end else begin
      coins_s = coins_r;
    end
    if (state_r == ST_WR) begin
      if (score_sum_s[SCORE_W]) begin
        score_s = {SCORE_W{1'b1}};
      end else begin
        score_s = score_sum_s[SCORE_W-1:0];
      end
    end else begin
      score_s = score_r;
    end
    if ((scan_done_s || (state_r == ST_WR)) && (coins_s == 11'd0)) begin
      level_clear_s = 1'b1;
    end else begin
      level_clear_s = level_clear_r;
    end
  end

  // Scan pointer, read-valid pipeline, latched tile and game counters
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      live_r        <= 1'b0;
      scan_addr_r   <= 11'd0;
      scan_vld_r    <= 1'b0;
      tile_addr_r   <= 11'd0;
      score_r       <= '0;
      coins_r       <= 11'd0;
      level_clear_r <= 1'b0;
    end else begin
      live_r        <= 1'b1;
      scan_vld_r    <= scan_issue_s;
      score_r       <= score_s;
      coins_r       <= coins_s;
      level_clear_r <= level_clear_s;
      if (scan_issue_s) begin
        scan_addr_r <= scan_addr_r + 11'd1;
      end
      if ((state_r == ST_IDLE) && frame_tick) begin
        tile_addr_r <= calc_addr_s;
      end
    end
  end

  // map_web also drops combinationally in a reset cycle so a WR that
  // coincides with reset never reaches the BRAM.
  always_comb begin
    map_enb   = enb_s & live_r;
    map_web   = web_s & live_r & ~reset;
    busy      = busy_s & live_r;
    map_addrb = 11'd0;
    if (live_r) begin
      map_addrb = addr_s;
    end else begin
      map_addrb = 11'd0;
    end
  end

  assign map_dinb    = TILE_EMPTY;
  assign score       = score_r;
  assign coins_left  = coins_r;
  assign level_clear = level_clear_r;

endmodule

// File: tb/tb_tile_map_writer.sv
module tb_tile_map_writer;
  import pacman_pkg::*;

  logic        clk_pix = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [11:0] pac_x = 12'd0;
  logic [11:0] pac_y = 12'd0;
  logic        map_enb;
  logic        map_web;
  logic [10:0] map_addrb;
  logic [3:0]  map_dinb;
  logic [3:0]  map_doutb;
  logic [15:0] score;
  logic [10:0] coins_left;
  logic        busy;
  logic        level_clear;

  logic [3:0]  mem [0:MAP_TILES-1];
  bit          mem_ready = 1'b0;
  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          exp_score = 0;
  int          exp_coins = 5;
  bit          exp_lvl = 1'b0;

  typedef struct {
    int addr;
    int cyc;
  } wr_exp_t;
  wr_exp_t sb_q[$];

  always #5 clk_pix = ~clk_pix;

  tile_map_writer #(.COIN_POINTS(10), .SCORE_W(16)) dut (
    .clk_pix     (clk_pix),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .pac_x       (pac_x),
    .pac_y       (pac_y),
    .map_enb     (map_enb),
    .map_web     (map_web),
    .map_addrb   (map_addrb),
    .map_dinb    (map_dinb),
    .map_doutb   (map_doutb),
    .score       (score),
    .coins_left  (coins_left),
    .busy        (busy),
    .level_clear (level_clear)
  );

  function automatic logic [3:0] init_tile(input int a);
    case (a)
      0, 100, 250, 700, 1295: return 4'd2;
      49:                     return 4'd1;
      300:                    return 4'd7;
      default:                return 4'd0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // BRAM port-B model and cycle counter
  always @(posedge clk_pix) begin
    cyc <= cyc + 1;
    if (!mem_ready) begin
      for (int i = 0; i < MAP_TILES; i++) mem[i] <= init_tile(i);
      mem_ready <= 1'b1;
    end else if (map_enb === 1'b1 && map_addrb < 11'(MAP_TILES)) begin
      if (map_web) mem[map_addrb] <= map_dinb;
      map_doutb <= mem[map_addrb];
    end
  end

  // Scoreboard: every write must match the next expected one
  always @(negedge clk_pix) begin : wr_mon
    wr_exp_t e;
    if (map_web === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_write_addr", {21'd0, map_addrb}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check_eq("wr_addr", {21'd0, map_addrb}, e.addr);
        check_eq("wr_din", {28'd0, map_dinb}, 32'd0);
        check_eq("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_scan(input int tick_at);
    int  n = 0;
    bit  done = 1'b0;
    @(negedge clk_pix);
    reset = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk_pix);
      frame_tick = 1'b0;
      if (i == 0) begin
        check_eq("scan_first_enb", {31'd0, map_enb}, 32'd1);
        check_eq("scan_first_addr", {21'd0, map_addrb}, 32'd0);
      end
      if (busy === 1'b1) n++;
      else done = 1'b1;
      if (i == tick_at) begin
        pac_x = 12'd400;
        pac_y = 12'd200;
        frame_tick = 1'b1;
      end
    end
    check_eq("scan_busy_cycles", n, 1297);
    check_eq("scan_coins", {21'd0, coins_left}, exp_coins);
    check_eq("scan_score", {16'd0, score}, exp_score);
    check_eq("scan_level", {31'd0, level_clear}, {31'd0, exp_lvl});
  endtask

  task automatic eat(input int px, input int py, input bit wr, input int addr);
    int tc;
    bit prev_lvl;
    @(negedge clk_pix);
    pac_x = 12'(px);
    pac_y = 12'(py);
    frame_tick = 1'b1;
    tc = cyc;
    prev_lvl = exp_lvl;
    if (wr) begin
      sb_q.push_back('{addr, tc + 4});
      exp_score += 10;
      exp_coins -= 1;
      exp_lvl = exp_lvl || (exp_coins == 0);
    end
    @(negedge clk_pix);
    frame_tick = 1'b0;
    check_eq("eat_busy_rd", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk_pix);
    check_eq("eat_level_before", {31'd0, level_clear}, {31'd0, prev_lvl});
    @(negedge clk_pix);
    check_eq("eat_level_after", {31'd0, level_clear}, {31'd0, exp_lvl});
    @(negedge clk_pix);
    check_eq("eat_busy_idle", {31'd0, busy}, 32'd0);
    check_eq("eat_score", {16'd0, score}, exp_score);
    check_eq("eat_coins", {21'd0, coins_left}, exp_coins);
    if (wr) check_eq("eat_map_cleared", {28'd0, mem[addr]}, 32'd0);
  endtask

  initial begin : stim
    int tc;
    repeat (3) @(negedge clk_pix);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_enb", {31'd0, map_enb}, 32'd0);
    check_eq("rst_web", {31'd0, map_web}, 32'd0);
    check_eq("rst_score", {16'd0, score}, 32'd0);
    check_eq("rst_coins", {21'd0, coins_left}, 32'd0);
    check_eq("rst_level", {31'd0, level_clear}, 32'd0);

    // Initial scan with a frame_tick dropped mid-scan
    wait_scan(100);

    eat(400, 200, 1'b1, 250);    // coin at tile (10,5)
    eat(400, 200, 1'b0, 250);    // already eaten
    eat(30, 30, 1'b0, 49);       // wall
    eat(480, 240, 1'b0, 300);    // code 7 behaves as empty
    eat(1910, 1070, 1'b1, 1295); // clamped to (47,26)
    eat(0, 0, 1'b1, 0);
    eat(160, 80, 1'b1, 100);

    // Reset during WAIT of a coin read: write abandoned, map rescanned
    @(negedge clk_pix);
    pac_x = 12'd1120;
    pac_y = 12'd560;
    frame_tick = 1'b1;
    tc = cyc;
    @(negedge clk_pix);
    frame_tick = 1'b0;
    @(negedge clk_pix);
    check_eq("wait_cycle", cyc, tc + 2);
    reset = 1'b1;
    repeat (2) @(negedge clk_pix);
    check_eq("mid_rst_web", {31'd0, map_web}, 32'd0);
    check_eq("mid_rst_score", {16'd0, score}, 32'd0);
    check_eq("mid_rst_coins", {21'd0, coins_left}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_map_kept", {28'd0, mem[700]}, 32'd2);
    exp_score = 0;
    exp_coins = 1;
    exp_lvl = 1'b0;
    wait_scan(40);

    eat(1120, 560, 1'b1, 700);   // last coin -> level clear
    eat(400, 200, 1'b0, 250);    // nothing left to change
    check_eq("level_sticky", {31'd0, level_clear}, 32'd1);
    check_eq("sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
